crc_fcs_sequencer: RTL and testbench

CRC_FCS_SEQUENCER -- requirements
Module: crc_fcs_sequencer

---
 rtl/crc_fcs_pkg.sv | 25 ++
 rtl/crc_fcs_sequencer_crc32.sv | 26 ++
 rtl/crc_fcs_sequencer.sv | 144 ++++++++++++++
 tb/tb_crc_fcs_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_fcs_pkg.sv
// Shared types and constants for the FCS sequencer and its CRC-32 engine.
package crc_fcs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2,
    FCS  = 2'd3
  } state_e;

  localparam int unsigned FCS_BYTES               = 4;
  localparam int unsigned DEFAULT_MIN_FRAME_BYTES = 60;
  localparam logic [7:0]  PAD_BYTE                = 8'h00;

  // Reflected Ethernet CRC-32 update, one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_fcs_sequencer_crc32.sv
// Byte-wide Ethernet CRC-32 engine; crc_o is the final (inverted) CRC of all bytes since reset.
module crc32
  import crc_fcs_pkg::*;
#(
  parameter logic [31:0] INIT = 32'hFFFFFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
    end else if (valid_i) begin
      state_q <= crc32_byte(state_q, data_i);
    end
  end

  assign crc_o = ~state_q;

endmodule

// File: rtl/crc_fcs_sequencer.sv
// Frame sequencer: forwards payload, optionally pads to a minimum length, appends a 4-byte CRC-32 FCS.
// Padding is built only when the macro FCS_PAD_EN is defined.
module crc_fcs_sequencer
  import crc_fcs_pkg::*;
#(
  parameter logic [31:0] INITIAL_CRC     = 32'hFFFFFFFF,
  parameter int unsigned MIN_FRAME_BYTES = DEFAULT_MIN_FRAME_BYTES
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tdata,
  input  logic       i_tvalid,
  input  logic       i_tlast,
  output logic       o_tready,
  output logic [7:0] o_tdata,
  output logic       o_tvalid,
  output logic       o_tlast,
  input  logic       i_tready
);

  localparam logic [1:0] LAST_IDX = 2'(FCS_BYTES - 1);

  if (MIN_FRAME_BYTES < 1 || MIN_FRAME_BYTES > 63) begin : g_bad_min
    $error("MIN_FRAME_BYTES must be in 1..63");
  end

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        load, accept, last_fcs;
  logic        crc_valid, crc_rst;
  logic [7:0]  crc_data;
  logic [31:0] crc;

`ifdef FCS_PAD_EN
  localparam logic [5:0] MIN_CNT = 6'(MIN_FRAME_BYTES);
  logic [5:0] cnt_q, cnt_d, cnt_inc;

  // Count restarts at 1 for a byte accepted in IDLE; saturates at 63.
  assign cnt_inc = (state_q == IDLE) ? 6'd1 : ((cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1);
`endif

  assign load     = !tvalid_q || i_tready;
  assign o_tready = load && (state_q == IDLE || state_q == DATA);
  assign accept   = i_tvalid && o_tready;
  assign last_fcs = load && (state_q == FCS) && (idx_q == LAST_IDX);
  assign crc_rst  = i_reset || last_fcs;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    crc_valid = 1'b0;
    crc_data  = i_tdata;
`ifdef FCS_PAD_EN
    cnt_d     = cnt_q;
`endif
    if (load) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      case (state_q)
        IDLE, DATA: begin
`ifdef FCS_PAD_EN
          if (state_q == IDLE) cnt_d = '0;
`endif
          if (accept) begin
            tdata_d   = i_tdata;
            tvalid_d  = 1'b1;
            crc_valid = 1'b1;
`ifdef FCS_PAD_EN
            cnt_d     = cnt_inc;
            if (!i_tlast)               state_d = DATA;
            else if (cnt_inc < MIN_CNT) state_d = PAD;
            else                        state_d = FCS;
`else
            state_d   = i_tlast ? FCS : DATA;
`endif
          end
        end
`ifdef FCS_PAD_EN
        PAD: begin
          tdata_d   = PAD_BYTE;
          tvalid_d  = 1'b1;
          crc_valid = 1'b1;
          crc_data  = PAD_BYTE;
          cnt_d     = cnt_inc;
          if (cnt_inc >= MIN_CNT) state_d = FCS;
        end
`endif
        FCS: begin
          tdata_d  = crc[{idx_q, 3'b000} +: 8];
          tvalid_d = 1'b1;
          idx_d    = idx_q + 2'd1;
          if (idx_q == LAST_IDX) begin
            tlast_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
`ifdef FCS_PAD_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
`ifdef FCS_PAD_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign o_tdata  = tdata_q;
  assign o_tvalid = tvalid_q;
  assign o_tlast  = tlast_q;

  crc32 #(
    .INIT(INITIAL_CRC)
  ) u_crc32 (
    .clk_i  (i_clk),
    .rst_i  (crc_rst),
    .valid_i(crc_valid),
    .data_i (crc_data),
    .crc_o  (crc)
  );

endmodule

// File: tb/tb_crc_fcs_sequencer.sv
// Self-checking bench for crc_fcs_sequencer: queue-based frame model plus literal vectors.
module tb_crc_fcs_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_tdata;
  logic       i_tvalid;
  logic       i_tlast;
  logic       o_tready;
  logic [7:0] o_tdata;
  logic       o_tvalid;
  logic       o_tlast;
  logic       i_tready = 1'b1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  exp_data[$];
  logic        exp_last[$];
  logic        rand_ready = 1'b0;
  int unsigned frame_len = 0;
  int unsigned last_len = 0;
  int unsigned frames_done = 0;

  always #5 i_clk = ~i_clk;

  crc_fcs_sequencer #(
    .INITIAL_CRC    (32'hFFFFFFFF),
    .MIN_FRAME_BYTES(60)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_tdata (i_tdata),
    .i_tvalid(i_tvalid),
    .i_tlast (i_tlast),
    .o_tready(o_tready),
    .o_tdata (o_tdata),
    .o_tvalid(o_tvalid),
    .o_tlast (o_tlast),
    .i_tready(i_tready)
  );

  function automatic logic [31:0] ref_crc(input logic [7:0] msg[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (msg[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ msg[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] payload[$]);
    logic [7:0]  all[$];
    logic [31:0] c;
    all = payload;
`ifdef FCS_PAD_EN
    while (all.size() < 60) all.push_back(8'h00);
`endif
    c = ref_crc(all);
    foreach (all[k]) begin
      exp_data.push_back(all[k]);
      exp_last.push_back(1'b0);
    end
    for (int b = 0; b < 4; b++) begin
      exp_data.push_back(c[8*b +: 8]);
      exp_last.push_back(b == 3);
    end
  endtask

  task automatic send(input logic [7:0] p[$], input int unsigned n);
    logic acc;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_tvalid = 1'b1;
      i_tdata  = p[i];
      i_tlast  = (i == n - 1) && (n == p.size());
      acc = 1'b0;
      for (int t = 0; t < 1000 && !acc; t++) begin
        if (t > 0) @(negedge i_clk);
        #4;
        acc = o_tready;
        @(posedge i_clk);
      end
      if (!acc) check("tready_timeout", 32'd0, 32'd1);
    end
    @(negedge i_clk);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 5000 && exp_data.size() > 0; t++) @(posedge i_clk);
    @(negedge i_clk);
    #4;
    check("drain_remaining", exp_data.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge i_clk);
      i_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Stream monitor: every transferred byte is checked against the model queue.
  initial begin
    logic       prev_stall;
    logic [9:0] prev_out;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge i_clk);
      #4;
      if (i_reset) begin
        prev_stall = 1'b0;
        frame_len  = 0;
        continue;
      end
      if (!o_tvalid) check("tlast_without_valid", o_tlast, 1'b0);
      if (prev_stall) check("stall_hold", {o_tvalid, o_tlast, o_tdata}, prev_out);
      if (o_tvalid && i_tready) begin
        if (exp_data.size() == 0) begin
          check("unexpected_byte", {o_tlast, o_tdata}, 9'h1FF);
        end else begin
          check("out_data", o_tdata, exp_data.pop_front());
          check("out_last", o_tlast, exp_last.pop_front());
        end
        frame_len++;
        if (o_tlast) begin
          last_len  = frame_len;
          frame_len = 0;
          frames_done++;
        end
      end
      prev_stall = o_tvalid && !i_tready;
      prev_out   = {o_tvalid, o_tlast, o_tdata};
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  s[$];
    logic [7:0]  one[$];
    logic [7:0]  lit[$];
    logic [7:0]  big[$];
    int unsigned fd;
    int unsigned full_len;

    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
`ifdef FCS_PAD_EN
    full_len = 64;
`else
    full_len = 13;
`endif

    i_reset  = 1'b1;
    i_tvalid = 1'b0;
    i_tdata  = 8'h00;
    i_tlast  = 1'b0;
    repeat (3) @(posedge i_clk);
    #4;
    check("reset_tvalid", o_tvalid, 1'b0);
    check("reset_tlast", o_tlast, 1'b0);
    check("reset_tdata", o_tdata, 8'h00);
    @(negedge i_clk);
    i_reset = 1'b0;
    #4;
    check("post_reset_tready", o_tready, 1'b1);

    check("model_crc_check", ref_crc(s), 32'hCBF43926);

    // "123456789" with an always-ready sink
`ifdef FCS_PAD_EN
    expect_frame(s);
`else
    lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    foreach (lit[k]) begin
      exp_data.push_back(lit[k]);
      exp_last.push_back(k == 12);
    end
`endif
    send(s, 9);
    wait_drain();
    check("frame1_len", last_len, full_len);

    // Single-byte frame
    one = '{8'hA5};
    expect_frame(one);
    send(one, 1);
    wait_drain();
`ifdef FCS_PAD_EN
    check("single_byte_len", last_len, 64);
`else
    check("single_byte_len", last_len, 5);
`endif

    // Two back-to-back frames under random downstream stalls
    fd = frames_done;
    rand_ready = 1'b1;
    expect_frame(s);
    expect_frame(s);
    send(s, 9);
    send(s, 9);
    wait_drain();
    rand_ready = 1'b0;
    check("b2b_frames", frames_done - fd, 2);
    check("b2b_len", last_len, full_len);

    // Reset after byte 5: partial frame dropped
    fd = frames_done;
    expect_frame(s);
    send(s, 5);
    i_reset = 1'b1;
    exp_data.delete();
    exp_last.delete();
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    #4;
    check("after_reset_tvalid", o_tvalid, 1'b0);
    check("after_reset_tlast", o_tlast, 1'b0);
    expect_frame(s);
    send(s, 9);
    wait_drain();
    check("after_reset_frames", frames_done - fd, 1);
    check("after_reset_len", last_len, full_len);

`ifdef FCS_PAD_EN
    one = '{8'h00};
    expect_frame(one);
    send(one, 1);
    wait_drain();
    check("pad_single_zero_len", last_len, 64);

    big.delete();
    for (int k = 0; k < 60; k++) big.push_back(8'(k * 7 + 3));
    expect_frame(big);
    send(big, 60);
    wait_drain();
    check("frame60_len", last_len, 64);

    big.push_back(8'h5A);
    expect_frame(big);
    send(big, 61);
    wait_drain();
    check("frame61_len", last_len, 65);
`endif

    repeat (3) @(posedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
